game_ctrl: RTL and testbench



---
 rtl/game_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: deadline-game sequencer.
// Owns the IDLE/PLAY/WIN/LOSE state machine and the BCD seconds countdown.
// The starting tens digit comes from the difficulty switches. Every output is
// a register loaded from the next-state values, so the reminder flags and
// win/lose flags change on the same edge as state and time.
module game_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int BASE_TENS      = 6,
  parameter int MIN_TENS       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [2:0] diff,
  input  logic       win_evt,
  input  logic       lose_evt,
  output logic [1:0] state,
  output logic       play_en,
  output logic       win,
  output logic       lose,
  output logic       end_game,
  output logic [3:0] secs_t,
  output logic [3:0] secs_u,
  output logic       reminder_flag1,
  output logic       reminder_flag2
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic signed [4:0] BASE_S     = 5'(BASE_TENS);
  localparam logic signed [4:0] MIN_S      = 5'(MIN_TENS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10,
    LOSE = 2'b11
  } state_t;

  state_t        st, st_n;
  logic          start_q;
  logic          start_rise;
  logic [FW-1:0] frame_cnt, frame_n;
  logic [3:0]    tens_load;
  logic [3:0]    t_n, u_n;
  logic [7:0]    dec_val;

  // Starting tens digit: base minus difficulty, saturated at the floor.
  // Five signed bits keep the negative intermediate (e.g. 6-7) representable.
  function automatic logic [3:0] clamp_tens(input logic [2:0] d);
    logic signed [4:0] raw;
    raw = BASE_S - $signed({2'b00, d});
    if (raw < MIN_S) return MIN_S[3:0];
    else             return raw[3:0];
  endfunction

  // Two-digit BCD decrement that sticks at 00 instead of wrapping.
  function automatic logic [7:0] bcd_dec(input logic [7:0] tu);
    if (tu == 8'h00)          return 8'h00;
    else if (tu[3:0] != 4'd0) return {tu[7:4], tu[3:0] - 4'd1};
    else                      return {tu[7:4] - 4'd1, 4'd9};
  endfunction

  // Next-state, next-time and next-frame-count logic.
  always_comb begin
    start_rise = start & ~start_q;
    tens_load  = clamp_tens(diff);
    dec_val    = bcd_dec({secs_t, secs_u});
    st_n       = st;
    t_n        = secs_t;
    u_n        = secs_u;
    frame_n    = frame_cnt;
    case (st)
      IDLE: begin
        t_n     = tens_load;
        u_n     = 4'd0;
        frame_n = '0;
        if (start_rise) st_n = PLAY;
      end
      PLAY: begin
        // Events outrank expiry; an event edge never decrements the time.
        if (lose_evt) begin
          st_n = LOSE;
        end else if (win_evt) begin
          st_n = WIN;
        end else if (frame_tick) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_n    = '0;
            {t_n, u_n} = dec_val;
            if (dec_val == 8'h00) st_n = LOSE;
          end else begin
            frame_n = frame_cnt + FW'(1);
          end
        end
      end
      WIN, LOSE: begin
        // Time stays frozen until a fresh start press returns to IDLE.
        if (start_rise) begin
          st_n    = IDLE;
          t_n     = tens_load;
          u_n     = 4'd0;
          frame_n = '0;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // State, time and registered output flags; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st             <= IDLE;
      start_q        <= 1'b0;
      frame_cnt      <= '0;
      secs_t         <= 4'd0;
      secs_u         <= 4'd0;
      play_en        <= 1'b0;
      win            <= 1'b0;
      lose           <= 1'b0;
      end_game       <= 1'b0;
      reminder_flag1 <= 1'b0;
      reminder_flag2 <= 1'b0;
    end else begin
      st             <= st_n;
      start_q        <= start;
      frame_cnt      <= frame_n;
      secs_t         <= t_n;
      secs_u         <= u_n;
      play_en        <= (st_n == PLAY);
      win            <= (st_n == WIN);
      lose           <= (st_n == LOSE);
      end_game       <= (st_n == WIN) || (st_n == LOSE);
      reminder_flag1 <= (st_n == PLAY) && (t_n == 4'd1);
      reminder_flag2 <= (st_n == PLAY) && (t_n == 4'd0);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed, self-checking bench for game_ctrl.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic [2:0] diff;
  logic       win_evt;
  logic       lose_evt;
  logic [1:0] state;
  logic       play_en, win, lose, end_game;
  logic [3:0] secs_t, secs_u;
  logic       reminder_flag1, reminder_flag2;

  int errors = 0;
  int checks = 0;

  game_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .start          (start),
    .diff           (diff),
    .win_evt        (win_evt),
    .lose_evt       (lose_evt),
    .state          (state),
    .play_en        (play_en),
    .win            (win),
    .lose           (lose),
    .end_game       (end_game),
    .secs_t         (secs_t),
    .secs_u         (secs_u),
    .reminder_flag1 (reminder_flag1),
    .reminder_flag2 (reminder_flag2)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n single-cycle frame_tick pulses, each followed by an idle cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_secs(input string tag, input logic [3:0] t, input logic [3:0] u);
    chk(tag, {24'd0, secs_t, secs_u}, {24'd0, t, u});
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; diff = 3'd0;
    win_evt = 1'b0; lose_evt = 1'b0;

    // Reset values
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_play_en", 32'(play_en), 32'd0);
    chk("rst_win_lose", {30'd0, win, lose}, 32'd0);
    chk("rst_end_game", 32'(end_game), 32'd0);
    chk_secs("rst_secs", 4'd0, 4'd0);
    chk("rst_flags", {30'd0, reminder_flag1, reminder_flag2}, 32'd0);

    // Release reset; IDLE loads 6/0
    rst = 1'b1;
    step(2);
    chk_secs("idle_load_d0", 4'd6, 4'd0);

    // Ignored inputs in IDLE
    win_evt = 1'b1; lose_evt = 1'b1;
    step();
    win_evt = 1'b0; lose_evt = 1'b0;
    frame_tick = 1'b1;
    step(200);
    frame_tick = 1'b0;
    step();
    chk("idle_ignore_state", 32'(state), 32'd0);
    chk_secs("idle_ignore_secs", 4'd6, 4'd0);

    // Countdown from 60
    start = 1'b1;
    step();
    start = 1'b0;
    chk("play_entry_state", 32'(state), 32'd1);
    chk("play_entry_en", 32'(play_en), 32'd1);
    chk_secs("play_entry_secs", 4'd6, 4'd0);
    ticks(59);
    chk_secs("tick59_secs", 4'd6, 4'd0);
    ticks(1);
    chk_secs("tick60_secs", 4'd5, 4'd9);
    chk("tick60_state", 32'(state), 32'd1);
    ticks(3539);
    chk_secs("tick3599_secs", 4'd0, 4'd1);
    chk("tick3599_flags", {30'd0, reminder_flag1, reminder_flag2}, 32'd1);
    ticks(1);
    chk_secs("expire_secs", 4'd0, 4'd0);
    chk("expire_state", 32'(state), 32'd3);
    chk("expire_lose", 32'(lose), 32'd1);
    chk("expire_end_game", 32'(end_game), 32'd1);
    chk("expire_play_en", 32'(play_en), 32'd0);

    // Restart from LOSE, then clamp with diff=7
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lose_to_idle", 32'(state), 32'd0);
    diff = 3'd7;
    step(2);
    chk_secs("idle_load_d7", 4'd1, 4'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clamp_state", 32'(state), 32'd1);
    chk_secs("clamp_secs", 4'd1, 4'd0);
    chk("clamp_flags", {30'd0, reminder_flag1, reminder_flag2}, 32'd2);
    ticks(60);
    chk_secs("clamp_tick60", 4'd0, 4'd9);
    chk("clamp_tick60_flags", {30'd0, reminder_flag1, reminder_flag2}, 32'd1);

    // win_evt on the tick that would reach 00; start pressed on the same edge
    ticks(480);
    chk_secs("pre_final_secs", 4'd0, 4'd1);
    ticks(59);
    frame_tick = 1'b1; win_evt = 1'b1; start = 1'b1;
    step();
    frame_tick = 1'b0; win_evt = 1'b0;
    chk("win_over_expiry", 32'(state), 32'd2);
    chk_secs("win_secs_held", 4'd0, 4'd1);
    chk("win_flag", {29'd0, win, lose, end_game}, 32'h5);

    // Held start does not leave WIN; ticks and events ignored too
    frame_tick = 1'b1; lose_evt = 1'b1;
    step(5);
    frame_tick = 1'b0; lose_evt = 1'b0;
    chk("win_hold_state", 32'(state), 32'd2);
    chk_secs("win_hold_secs", 4'd0, 4'd1);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("win_to_idle", 32'(state), 32'd0);
    step();
    chk_secs("restart_idle_secs", 4'd1, 4'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_play", 32'(state), 32'd1);

    // Simultaneous win_evt and lose_evt: lose wins
    win_evt = 1'b1; lose_evt = 1'b1;
    step();
    win_evt = 1'b0; lose_evt = 1'b0;
    chk("both_evt_state", 32'(state), 32'd3);
    chk("both_evt_flags", {30'd0, win, lose}, 32'd1);

    // Reset mid-play at 3/4
    start = 1'b1;
    step();
    start = 1'b0;
    diff = 3'd2;
    step(2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_secs("d2_entry_secs", 4'd4, 4'd0);
    ticks(360);
    chk_secs("mid_secs", 4'd3, 4'd4);
    chk("mid_state", 32'(state), 32'd1);
    rst = 1'b0; lose_evt = 1'b1;
    step();
    rst = 1'b1; lose_evt = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk_secs("midrst_secs", 4'd0, 4'd0);
    chk("midrst_outs", {26'd0, play_en, win, lose, end_game, reminder_flag1, reminder_flag2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
